if_id_fetch_controller: RTL and testbench
=========================================

IF_ID_FETCH_CONTROLLER -- requirements
Module: if_id_fetch_controller

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: pcValue  input  32  current program-counter output.
REQ-004 SHALL have port: pcHold  output  1  drives the program counter's hold (pcFlush) input; 1 = PC keeps its value.
REQ-005 SHALL have port: imemReq  output  1  instruction-memory request.
REQ-006 SHALL have port: imemAddr  output  32  registered request address.
REQ-007 SHALL have port: imemAck  input  1  one-cycle pulse; imemData is valid in that cycle.
REQ-008 SHALL have port: imemData  input  32  fetched instruction word.
REQ-009 SHALL have port: decodeStall  input  1  decode cannot accept a new instruction.
REQ-010 SHALL have port: branchFlush  input  1  redirect; discard in-flight and IF/ID contents.
REQ-011 SHALL have port: ifIdInstruction  output  32  IF/ID instruction register.
REQ-012 SHALL have port: ifIdPcPlus4  output  32  IF/ID PC+4 register.
REQ-013 SHALL have port: ifIdValid  output  1  IF/ID contents valid.
REQ-014 SHALL have port: stallCycles  output  32  fetch stall counter (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, HOLD, DISCARD.
REQ-016 IDLE: imemReq=0; imemAddr<=pcValue; next FETCH; minimum fetch latency 2 cycles.
REQ-017 FETCH: imemReq=1; imemAddr stable until imemAck.
REQ-018 FETCH, imemAck=1, decodeStall=0, branchFlush=0: ifIdInstruction<=imemData, ifIdPcPlus4<=imemAddr+4, ifIdValid<=1; next IDLE.
REQ-019 FETCH, imemAck=1, decodeStall=1, branchFlush=0: capture imemData into internal buffer; IF/ID holds; next HOLD.
REQ-020 HOLD: imemReq=0; when decodeStall=0, load buffer into IF/ID (ifIdValid<=1); next IDLE.
REQ-021 decodeStall=1 with no transfer: IF/ID registers SHALL hold their values.
REQ-022 pcHold SHALL be 0 only in the cycle IF/ID loads a fetched word (REQ-018/020) or when branchFlush=1; otherwise 1.
REQ-023 branchFlush has priority over decodeStall and imemAck: ifIdValid<=0, ifIdInstruction<=0x00000000 next cycle.
REQ-024 branchFlush in FETCH without imemAck: next DISCARD; DISCARD keeps imemReq=1, drops data on imemAck, then IDLE.
REQ-025 branchFlush in FETCH with imemAck, in HOLD, or in IDLE: drop data/buffer; next IDLE.
REQ-026 branchFlush in DISCARD: stay DISCARD until imemAck.
REQ-027 imemAck outside FETCH/DISCARD SHALL be ignored.
REQ-028 ifIdPcPlus4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).

Reset
REQ-029 On reset=1, asynchronously: state=IDLE, imemReq=0, imemAddr=0, ifIdInstruction=0, ifIdPcPlus4=0, ifIdValid=0, buffer=0, stallCycles=0; pcHold=1 while reset asserted.
REQ-030 Reset mid-transaction SHALL abandon any outstanding request; an imemAck in the first cycle after release SHALL be ignored (state IDLE).

Configuration
REQ-031 Macro FETCH_STALL_COUNTER_EN defined: stallCycles increments each cycle pcHold=1 and reset=0, saturating at 0xFFFFFFFF.
REQ-032 Macro FETCH_STALL_COUNTER_EN undefined: stallCycles SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-033 Reset release, pcValue=0x00000000, imemAck 1 cycle after req, data 0x20080005 -> ifIdInstruction=0x20080005, ifIdPcPlus4=0x4, ifIdValid=1, pcHold=0 for exactly 1 cycle.
REQ-034 decodeStall=1 during ack with data 0x8C090000 -> state HOLD, IF/ID unchanged; deassert stall 3 cycles later -> IF/ID loads 0x8C090000 next edge.
REQ-035 branchFlush in FETCH before ack -> ifIdValid=0, DISCARD; later ack with 0xDEADBEEF -> data never appears in IF/ID.
REQ-036 branchFlush and decodeStall both 1 with IF/ID valid -> ifIdValid=0, ifIdInstruction=0 next cycle.
REQ-037 pcValue=0xFFFFFFFC fetched -> ifIdPcPlus4=0x00000000.
REQ-038 With FETCH_STALL_COUNTER_EN, ack latency 4 cycles per fetch over 3 fetches -> stallCycles matches counted pcHold=1 cycles; reset mid-fetch -> all outputs per REQ-029, stallCycles=0.

Source files
------------

// File: rtl/if_id_fetch_controller_if.sv
// Bundles the fetch controller's program-counter, instruction-memory,
// decode-side and IF/ID pipeline-register signals into one interface.
// The master modport belongs to the fetch controller. The slave modport
// belongs to whatever surrounds it: the PC, the memory and the decode stage.
interface if_id_fetch_controller_if;
   logic [31:0] pcValue;
   logic        pcHold;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck;
   logic [31:0] imemData;
   logic        decodeStall;
   logic        branchFlush;
   logic [31:0] ifIdInstruction;
   logic [31:0] ifIdPcPlus4;
   logic        ifIdValid;
   logic [31:0] stallCycles;

   modport master (
      input  pcValue, imemAck, imemData, decodeStall, branchFlush,
      output pcHold, imemReq, imemAddr, ifIdInstruction, ifIdPcPlus4,
             ifIdValid, stallCycles
   );

   modport slave (
      output pcValue, imemAck, imemData, decodeStall, branchFlush,
      input  pcHold, imemReq, imemAddr, ifIdInstruction, ifIdPcPlus4,
             ifIdValid, stallCycles
   );
endinterface

// File: rtl/if_id_fetch_controller.sv
// Instruction fetch controller feeding the IF/ID pipeline register.
// Each fetch works like this:
//   - It latches the PC into imemAddr.
//   - It holds imemReq until the memory acknowledges.
//   - It writes the returned word into IF/ID.
// If decode is stalled when the word arrives, the word is parked in a
// buffer until decode frees up. A branch redirect empties IF/ID. An
// in-flight request is then drained without its data ever being used.
// Optional feature: define FETCH_STALL_COUNTER_EN to get a saturating
// count of cycles in which the PC was held. Without it, stallCycles is
// tied to zero.
module if_id_fetch_controller (
   input logic                      clk,
   input logic                      reset,
   if_id_fetch_controller_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      DISCARD
   } fetchState_t;

   fetchState_t state;
   logic [31:0] fetchBuffer;
   logic        imemReqReg;
   logic [31:0] imemAddrReg;
   logic [31:0] instrReg;
   logic [31:0] pcPlus4Reg;
   logic        validReg;
   logic        loadFromMem;
   logic        loadFromBuffer;
   logic        pcHold;

   // An IF/ID load happens either straight from memory or from the parked buffer.
   assign loadFromMem    = (state == FETCH) && bus.imemAck && !bus.decodeStall && !bus.branchFlush;
   assign loadFromBuffer = (state == HOLD) && !bus.decodeStall && !bus.branchFlush;
   assign pcHold         = reset | ~(loadFromMem | loadFromBuffer | bus.branchFlush);

   assign bus.pcHold          = pcHold;
   assign bus.imemReq         = imemReqReg;
   assign bus.imemAddr        = imemAddrReg;
   assign bus.ifIdInstruction = instrReg;
   assign bus.ifIdPcPlus4     = pcPlus4Reg;
   assign bus.ifIdValid       = validReg;

   // This block holds the fetch sequencing state, the memory request, the parked buffer and IF/ID.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         imemReqReg  <= 1'b0;
         imemAddrReg <= 32'h0;
         fetchBuffer <= 32'h0;
         instrReg    <= 32'h0;
         pcPlus4Reg  <= 32'h0;
         validReg    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!bus.branchFlush) begin
                  imemAddrReg <= bus.pcValue;
                  imemReqReg  <= 1'b1;
                  state       <= FETCH;
               end
            end
            FETCH: begin
               if (bus.branchFlush) begin
                  if (bus.imemAck) begin
                     imemReqReg <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     state <= DISCARD;
                  end
               end else if (bus.imemAck) begin
                  imemReqReg <= 1'b0;
                  if (bus.decodeStall) begin
                     fetchBuffer <= bus.imemData;
                     state       <= HOLD;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            HOLD: begin
               if (bus.branchFlush) begin
                  fetchBuffer <= 32'h0;
                  state       <= IDLE;
               end else if (!bus.decodeStall) begin
                  state <= IDLE;
               end
            end
            DISCARD: begin
               if (bus.imemAck) begin
                  imemReqReg <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               imemReqReg <= 1'b0;
               state      <= IDLE;
            end
         endcase

         if (bus.branchFlush) begin
            validReg <= 1'b0;
            instrReg <= 32'h0;
         end else if (loadFromMem) begin
            instrReg   <= bus.imemData;
            pcPlus4Reg <= imemAddrReg + 32'd4;
            validReg   <= 1'b1;
         end else if (loadFromBuffer) begin
            instrReg   <= fetchBuffer;
            pcPlus4Reg <= imemAddrReg + 32'd4;
            validReg   <= 1'b1;
         end
      end
   end

`ifdef FETCH_STALL_COUNTER_EN
   logic [31:0] stallCount;

   // This counts the cycles in which the PC is held, and sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stallCount <= 32'h0;
      end else if (pcHold && (stallCount != 32'hFFFF_FFFF)) begin
         stallCount <= stallCount + 32'd1;
      end
   end

   assign bus.stallCycles = stallCount;
`else
   assign bus.stallCycles = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_fetch_controller.sv
// Directed bench for if_id_fetch_controller.
// Expected IF/ID contents are queued when the memory acknowledges a fetch.
// They are popped and compared when the controller loads IF/ID.
// Build with FETCH_STALL_COUNTER_EN defined to check the stall counter
// against its reference model.
module tb_if_id_fetch_controller;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pcPlus4;
   } expEntry_t;

   logic        clk;
   logic        reset;
   int          checks;
   int          errors;
   logic [31:0] expStall;
   logic [31:0] prevInstr;
   logic [31:0] prevPcPlus4;
   expEntry_t   expQ[$];

   if_id_fetch_controller_if bus ();

   if_id_fetch_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   // This generates a free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // This is the reference count of cycles in which the PC was told to hold.
   always @(posedge clk or posedge reset) begin
      if (reset) expStall <= 32'h0;
      else if (bus.pcHold === 1'b1 && expStall != 32'hFFFF_FFFF) expStall <= expStall + 32'd1;
   end

   // This is a watchdog so that a hung handshake still terminates the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkStall(input string tag);
`ifdef FETCH_STALL_COUNTER_EN
      checkVal(tag, bus.stallCycles, expStall);
`else
      checkVal(tag, bus.stallCycles, 32'h0);
`endif
   endtask

   task automatic checkResetState(input string tag);
      checkVal({tag, "_req"}, bus.imemReq, 1'b0);
      checkVal({tag, "_addr"}, bus.imemAddr, 32'h0);
      checkVal({tag, "_instr"}, bus.ifIdInstruction, 32'h0);
      checkVal({tag, "_pc4"}, bus.ifIdPcPlus4, 32'h0);
      checkVal({tag, "_valid"}, bus.ifIdValid, 1'b0);
      checkVal({tag, "_pcHold"}, bus.pcHold, 1'b1);
      checkVal({tag, "_stall"}, bus.stallCycles, 32'h0);
   endtask

   task automatic waitReq(input string tag, input int maxCycles);
      int n = 0;
      while (bus.imemReq !== 1'b1 && n < maxCycles) begin
         tick();
         n++;
      end
      checkVal(tag, bus.imemReq, 1'b1);
   endtask

   // This pops the oldest expected IF/ID contents and compares them with the pipeline register.
   task automatic checkOutput(input string tag);
      expEntry_t e;
      checkVal({tag, "_pending"}, 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
         e = expQ.pop_front();
         checkVal({tag, "_instr"}, bus.ifIdInstruction, e.instr);
         checkVal({tag, "_pc4"}, bus.ifIdPcPlus4, e.pcPlus4);
         checkVal({tag, "_valid"}, bus.ifIdValid, 1'b1);
      end
   endtask

   // This fetches one word from addr with the given acknowledge latency and checks the load into IF/ID.
   task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                input logic [31:0] data, input int latency);
      expEntry_t e;
      bus.pcValue     = addr;
      bus.decodeStall = 1'b0;
      bus.branchFlush = 1'b0;
      bus.imemAck     = 1'b0;
      waitReq({tag, "_req"}, 10);
      checkVal({tag, "_addr"}, bus.imemAddr, addr);
      for (int i = 1; i < latency; i++) begin
         checkVal({tag, "_waitHold"}, bus.pcHold, 1'b1);
         tick();
      end
      bus.imemAck  = 1'b1;
      bus.imemData = data;
      e.instr      = data;
      e.pcPlus4    = addr + 32'd4;
      expQ.push_back(e);
      #1;
      checkVal({tag, "_loadHold"}, bus.pcHold, 1'b0);
      tick();
      bus.imemAck = 1'b0;
      #1;
      checkOutput(tag);
      checkVal({tag, "_afterHold"}, bus.pcHold, 1'b1);
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      reset            = 1'b0;
      bus.pcValue      = 32'h0;
      bus.imemAck      = 1'b0;
      bus.imemData     = 32'h0;
      bus.decodeStall  = 1'b0;
      bus.branchFlush  = 1'b0;

      $display("[TB] asynchronous reset before the first clock edge");
      #2 reset = 1'b1;
      #1 checkResetState("reset");
      tick();
      tick();
      reset = 1'b0;

      $display("[TB] first fetch, minimum latency");
      applyStimulus("first", 32'h0000_0000, 32'h2008_0005, 1);

      $display("[TB] fetch with a four-cycle acknowledge latency");
      applyStimulus("slow", 32'h0000_0004, 32'h0100_0113, 4);

      $display("[TB] decode stall during the acknowledge parks the word");
      prevInstr       = bus.ifIdInstruction;
      prevPcPlus4     = bus.ifIdPcPlus4;
      bus.pcValue     = 32'h0000_0008;
      waitReq("park_req", 10);
      bus.decodeStall = 1'b1;
      bus.imemAck     = 1'b1;
      bus.imemData    = 32'h8C09_0000;
      expQ.push_back('{instr: 32'h8C09_0000, pcPlus4: 32'h0000_000C});
      #1 checkVal("park_ackHold", bus.pcHold, 1'b1);
      tick();
      bus.imemData = 32'h1111_1111;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkVal("park_instrHeld", bus.ifIdInstruction, prevInstr);
         checkVal("park_pc4Held", bus.ifIdPcPlus4, prevPcPlus4);
         checkVal("park_reqLow", bus.imemReq, 1'b0);
         checkVal("park_pcHold", bus.pcHold, 1'b1);
         tick();
         bus.imemAck = 1'b0;
      end
      bus.decodeStall = 1'b0;
      bus.pcValue     = 32'h0000_000C;
      #1 checkVal("park_releaseHold", bus.pcHold, 1'b0);
      tick();
      #1 checkOutput("park");

      $display("[TB] branch flush before the acknowledge drains the request");
      waitReq("drain_req", 10);
      bus.branchFlush = 1'b1;
      #1 checkVal("drain_flushHold", bus.pcHold, 1'b0);
      bus.pcValue = 32'h0000_0100;
      tick();
      bus.branchFlush = 1'b0;
      #1;
      checkVal("drain_valid", bus.ifIdValid, 1'b0);
      checkVal("drain_instr", bus.ifIdInstruction, 32'h0);
      checkVal("drain_reqKept", bus.imemReq, 1'b1);
      checkVal("drain_addrKept", bus.imemAddr, 32'h0000_000C);
      tick();
      checkVal("drain_waitHold", bus.pcHold, 1'b1);
      bus.imemAck  = 1'b1;
      bus.imemData = 32'hDEAD_BEEF;
      #1 checkVal("drain_ackHold", bus.pcHold, 1'b1);
      tick();
      bus.imemAck = 1'b0;
      #1;
      checkVal("drain_instrDropped", bus.ifIdInstruction, 32'h0);
      checkVal("drain_validDropped", bus.ifIdValid, 1'b0);
      checkVal("drain_reqDone", bus.imemReq, 1'b0);
      applyStimulus("target", 32'h0000_0100, 32'h00A0_0093, 1);

      $display("[TB] branch flush wins over a decode stall");
      bus.branchFlush = 1'b1;
      bus.decodeStall = 1'b1;
      tick();
      bus.branchFlush = 1'b0;
      bus.decodeStall = 1'b0;
      #1;
      checkVal("flushStall_valid", bus.ifIdValid, 1'b0);
      checkVal("flushStall_instr", bus.ifIdInstruction, 32'h0);

      $display("[TB] PC+4 wraps at the top of the address space");
      applyStimulus("wrap", 32'hFFFF_FFFC, 32'h1234_5678, 2);

      $display("[TB] three slow fetches against the stall counter");
      applyStimulus("cnt0", 32'h0000_0200, 32'h0000_0013, 4);
      checkStall("cnt0_stall");
      applyStimulus("cnt1", 32'h0000_0204, 32'h0010_0093, 4);
      checkStall("cnt1_stall");
      applyStimulus("cnt2", 32'h0000_0208, 32'h0020_0113, 4);
      checkStall("cnt2_stall");

      $display("[TB] reset in the middle of a fetch");
      bus.pcValue = 32'h0000_0300;
      waitReq("midReset_req", 10);
      tick();
      #2 reset = 1'b1;
      #1 checkResetState("midReset");
      @(negedge clk);
      @(negedge clk);
      bus.imemAck  = 1'b1;
      bus.imemData = 32'h5555_5555;
      reset        = 1'b0;
      tick();
      bus.imemAck = 1'b0;
      #1;
      checkVal("postReset_validLow", bus.ifIdValid, 1'b0);
      checkVal("postReset_instrLow", bus.ifIdInstruction, 32'h0);
      checkVal("postReset_req", bus.imemReq, 1'b1);
      checkVal("postReset_addr", bus.imemAddr, 32'h0000_0300);
      applyStimulus("postReset", 32'h0000_0300, 32'h0030_0193, 1);
      checkStall("postReset_stall");

      checkVal("scoreboard_empty", 32'(expQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
